// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues fetches to inst_if, and holds one fetched
// instruction in an IF/ID slot. Redirects arriving mid-fetch are deferred to the next done.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  output logic [63:0] inst_address,
  output logic        ce,
  input  logic        stall_from_inst_if,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  input  logic        trap_valid,
  input  logic [63:0] trap_target,
  input  logic        halt,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {StBoot, StIdle, StBusy, StHalt} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        ce_q;
  logic        pend_valid_q;
  logic        pend_trap_q;
  logic [63:0] pend_target_q;

  logic        evt;
  logic [63:0] evt_target;
  logic        done;
  logic        squash;
  logic        drain;
  logic        pend_keep;
  logic [63:0] squash_pc;

  always_comb begin
    evt        = trap_valid | redirect_valid;
    evt_target = trap_valid ? trap_target : redirect_target;
    done       = (state_q == StBusy) && !stall_from_inst_if;
    squash     = pend_valid_q | evt | halt;
    drain      = if_valid & id_ready;
    // A pending trap survives a later plain redirect.
    pend_keep  = pend_valid_q & pend_trap_q & ~trap_valid;
    if (trap_valid)                        squash_pc = trap_target;
    else if (pend_valid_q && pend_trap_q)  squash_pc = pend_target_q;
    else if (redirect_valid)               squash_pc = redirect_target;
    else if (pend_valid_q)                 squash_pc = pend_target_q;
    else                                   squash_pc = pc_q;
  end

  assign inst_address = pc_q;
  assign ce           = ce_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      ce_q          <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= 64'd0;
      if_valid      <= 1'b0;
      if_pc         <= 64'd0;
      if_inst       <= 32'd0;
    end else begin
      case (state_q)
        StBoot: state_q <= StIdle;
        StIdle: begin
          if (drain || evt) if_valid <= 1'b0;
          if (evt) pc_q <= evt_target;
          if (halt) begin
            state_q  <= StHalt;
            if_valid <= 1'b0;
          end else if (!if_valid || id_ready) begin
            state_q <= StBusy;
            ce_q    <= 1'b1;
          end
        end
        StBusy: begin
          if (!done) begin
            if (drain || evt) if_valid <= 1'b0;
            if (evt && !pend_keep) begin
              pend_valid_q  <= 1'b1;
              pend_trap_q   <= trap_valid;
              pend_target_q <= evt_target;
            end
          end else if (!squash) begin
            if_valid <= 1'b1;
            if_pc    <= pc_q;
            if_inst  <= inst;
            pc_q     <= pc_q + 64'd4;
            state_q  <= StIdle;
            ce_q     <= 1'b0;
          end else begin
            // Wrong-path or halted fetch: drop the instruction, retarget.
            if_valid      <= 1'b0;
            pc_q          <= squash_pc;
            pend_valid_q  <= 1'b0;
            pend_trap_q   <= 1'b0;
            pend_target_q <= 64'd0;
            if (halt) begin
              state_q <= StHalt;
              ce_q    <= 1'b0;
            end
          end
        end
        StHalt: begin
          if_valid <= 1'b0;
          ce_q     <= 1'b0;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller directly upstream of `inst_if`. It owns the program counter and drives `inst_address`/`ce` into `inst_if`. It consumes `inst` and `stall_from_inst_if`, and latches each completed fetch into a one-entry IF/ID output slot for decode. It also absorbs branch/jump redirects and trap redirects that arrive while a fetch is in flight, so the address seen by `inst_if` never changes mid-transaction.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC loaded at reset.
- `ACLK` in 1: clock; all state updates on rising edge.
- `ARESETn` in 1: synchronous, active-low reset.
- `inst_address` out 64: current PC; drives `inst_if.inst_address`.
- `ce` out 1: fetch enable to `inst_if`.
- `stall_from_inst_if` in 1: from `inst_if`; high while the fetch is not yet valid.
- `inst` in 32: fetched instruction from `inst_if`.
- `redirect_valid` in 1: branch/jump resolved taken (EX stage), single-cycle pulse.
- `redirect_target` in 64: target PC for `redirect_valid`.
- `trap_valid` in 1: trap/mret redirect, single-cycle pulse.
- `trap_target` in 64: target PC for `trap_valid`.
- `halt` in 1: stop fetching (ebreak); sticky until reset.
- `id_ready` in 1: decode consumes the slot this cycle when `if_valid` is high.
- `if_valid` out 1: output slot holds a valid instruction.
- `if_pc` out 64: PC of the slot instruction.
- `if_inst` out 32: slot instruction.

## Operation
- Registered state: `pc`, state ∈ {BOOT, IDLE, BUSY, HALT}, `pend_valid`, `pend_trap`, `pend_target`, and the slot (`if_valid`, `if_pc`, `if_inst`).
- Reset values: `pc`=RESET_PC, state=BOOT, `pend_*`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0. `ce`=0 and `inst_address`=RESET_PC during and after reset.
- Outputs: `inst_address`=`pc`. `ce`=1 iff state==BUSY. Both are driven only from registers.
- `done` = BUSY && !`stall_from_inst_if`.
- Event priority: `trap_valid` > `redirect_valid`. The event target E is `trap_target` if `trap_valid`, else `redirect_target`.
- Any event flushes the slot: `if_valid`<=0 in the same edge, overriding consumption and capture.
- BOOT: always goes to IDLE next cycle (one dead cycle after reset).
- IDLE:
  - An event sets `pc`<=E.
  - If `halt`, go to HALT.
  - Else if (!`if_valid` || `id_ready`), go to BUSY.
  - Otherwise remain in IDLE.
- BUSY, not `done`:
  - `pc` is held.
  - An event writes the pending register: `pend_target`<=E, `pend_valid`<=1, `pend_trap`<=`trap_valid`.
  - A later plain redirect does not overwrite a pending trap. Any other later event overwrites.
- BUSY, `done`:
  - squash = `pend_valid` || event this cycle || `halt`.
  - If !squash: capture `if_inst`<=`inst`, `if_pc`<=`pc`, `if_valid`<=1, `pc`<=`pc`+4 (64-bit wrap), go to IDLE.
  - If squash: discard `inst`, keep `if_valid`=0, clear `pend_*`.
    - `pc` takes the event target this cycle, else `pend_target`. A same-cycle trap beats a pending redirect; a pending trap beats a same-cycle redirect.
    - Next state: HALT if `halt`, else BUSY (the slot is empty).
- BUSY with `halt` and not `done`: remain in BUSY until `done`. `ce` never drops mid-transaction.
- HALT: `ce`=0, `if_valid`=0, events ignored; exit only by reset.
- Slot drain: `if_valid`<=0 when `if_valid` && `id_ready` && no capture this edge.
- Invariant: entering BUSY guarantees the slot is empty by the first cycle `done` can occur. Capture never overwrites a valid, unconsumed entry. The bench asserts this.

## Timing
- Fetch issue: IDLE→BUSY in one cycle. `inst_address` is stable for every cycle `ce`=1.
- Zero-wait memory: `done` in the first BUSY cycle. The slot is valid the next cycle. Throughput is 1 instruction / 2 cycles.
- N wait cycles give N+1 BUSY cycles.
- Redirect in IDLE: the next fetch uses the target with no bubble beyond IDLE→BUSY.
- Redirect in BUSY: takes effect at the following `done`; the wrong-path instruction is never exposed.
- Reset asserted in any state, including BUSY with a pending redirect: all registers take reset values at that edge. Pending state is lost.

## Test plan
- Reset release, zero-wait memory returning 32'h00000013: `ce` rises on cycle 2 at address 8000_0000. `if_valid`=1 with `if_pc`=8000_0000 on cycle 3. The next fetch is at 8000_0004.
- Memory stalls 3 cycles with `redirect_valid` at stall cycle 1 (target 8000_0100): `inst_address` stays 8000_0000 throughout. The completed instruction is dropped (`if_valid`=0). The next fetch is at 8000_0100.
- `trap_valid` (target 8000_0200) and `redirect_valid` (8000_0100) in the same cycle, then a second redirect while stalled: the next fetch is at 8000_0200.
- `id_ready`=0 for 5 cycles with the slot full: `ce` stays 0 and `if_inst`/`if_pc` stay stable. The entry drains on `id_ready`=1 and a fetch issues the next cycle.
- `halt` during a stalled fetch: `ce` stays 1 until valid, the instruction is discarded, the block enters HALT, and `ce`=0 thereafter. A later redirect has no effect.
- PC wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC gives a second fetch at 64'h0. `ARESETn`=0 mid-BUSY gives `ce`=0 and `pc`=RESET_PC on the next cycle.
